// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for a 5-stage pipeline: tracks in-flight
// destinations EX..WB, selects EX forwarding sources, and issues stalls/flushes.
module pipe_hazard_unit #(
  parameter int NUM_STAGES = 3,
  parameter int MEM_LAT    = 1,
  parameter int RA_W       = 5,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             freeze_i,
  input  logic             id_valid_i,
  input  logic [RA_W-1:0]  id_rs_i,
  input  logic [RA_W-1:0]  id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic [RA_W-1:0]  id_dest_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             ex_br_taken_i,
  output logic             pc_hold_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic [SEL_W-1:0] fwd_a_sel_o,
  output logic [SEL_W-1:0] fwd_b_sel_o,
  output logic             id_byp_a_o,
  output logic             id_byp_b_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic            valid_q    [NUM_STAGES];
  logic            valid_d    [NUM_STAGES];
  logic [RA_W-1:0] dest_q     [NUM_STAGES];
  logic [RA_W-1:0] dest_d     [NUM_STAGES];
  logic            regwrite_q [NUM_STAGES];
  logic            regwrite_d [NUM_STAGES];
  logic            memread_q  [NUM_STAGES];
  logic            memread_d  [NUM_STAGES];

  logic [RA_W-1:0] ex_rs_q, ex_rs_d;
  logic [RA_W-1:0] ex_rt_q, ex_rt_d;
  logic            ex_use_rs_q, ex_use_rs_d;
  logic            ex_use_rt_q, ex_use_rt_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_stall;
  logic flush;
  logic stall;

  function automatic logic match(input logic v, input logic rw,
                                 input logic [RA_W-1:0] dest,
                                 input logic [RA_W-1:0] r, input logic use_r);
    return v & rw & use_r & (dest == r) & (r != '0);
  endfunction

  // A load still inside its latency window cannot be forwarded yet.
  always_comb begin
    load_stall = 1'b0;
    for (int k = 0; k < MEM_LAT; k++) begin
      if (memread_q[k] &&
          (match(valid_q[k], regwrite_q[k], dest_q[k], id_rs_i, id_use_rs_i) ||
           match(valid_q[k], regwrite_q[k], dest_q[k], id_rt_i, id_use_rt_i)))
        load_stall = 1'b1;
    end
    load_stall = load_stall & id_valid_i;
    flush      = ex_br_taken_i & ~freeze_i;
    stall      = load_stall & ~flush & ~freeze_i;
  end

  assign pc_hold_o     = freeze_i | stall;
  assign ifid_flush_o  = flush;
  assign idex_bubble_o = flush | stall;

  // Scan oldest to youngest so the youngest eligible producer wins.
  always_comb begin
    fwd_a_sel_o = '0;
    fwd_b_sel_o = '0;
    for (int k = NUM_STAGES - 1; k >= 1; k--) begin
      if (!(memread_q[k] && (k <= MEM_LAT))) begin
        if (match(valid_q[k], regwrite_q[k], dest_q[k], ex_rs_q, ex_use_rs_q))
          fwd_a_sel_o = SEL_W'(k);
        if (match(valid_q[k], regwrite_q[k], dest_q[k], ex_rt_q, ex_use_rt_q))
          fwd_b_sel_o = SEL_W'(k);
      end
    end
  end

  assign id_byp_a_o = id_valid_i &
    match(valid_q[NUM_STAGES-1], regwrite_q[NUM_STAGES-1], dest_q[NUM_STAGES-1],
          id_rs_i, id_use_rs_i);
  assign id_byp_b_o = id_valid_i &
    match(valid_q[NUM_STAGES-1], regwrite_q[NUM_STAGES-1], dest_q[NUM_STAGES-1],
          id_rt_i, id_use_rt_i);

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      valid_d[k]    = valid_q[k];
      dest_d[k]     = dest_q[k];
      regwrite_d[k] = regwrite_q[k];
      memread_d[k]  = memread_q[k];
    end
    ex_rs_d     = ex_rs_q;
    ex_rt_d     = ex_rt_q;
    ex_use_rs_d = ex_use_rs_q;
    ex_use_rt_d = ex_use_rt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (!freeze_i) begin
      for (int k = 1; k < NUM_STAGES; k++) begin
        valid_d[k]    = valid_q[k-1];
        dest_d[k]     = dest_q[k-1];
        regwrite_d[k] = regwrite_q[k-1];
        memread_d[k]  = memread_q[k-1];
      end
      if (flush || stall) begin
        valid_d[0]    = 1'b0;
        dest_d[0]     = '0;
        regwrite_d[0] = 1'b0;
        memread_d[0]  = 1'b0;
        ex_rs_d       = '0;
        ex_rt_d       = '0;
        ex_use_rs_d   = 1'b0;
        ex_use_rt_d   = 1'b0;
      end else begin
        valid_d[0]    = id_valid_i;
        dest_d[0]     = id_dest_i;
        regwrite_d[0] = id_regwrite_i;
        memread_d[0]  = id_memread_i;
        ex_rs_d       = id_rs_i;
        ex_rt_d       = id_rt_i;
        ex_use_rs_d   = id_use_rs_i;
        ex_use_rt_d   = id_use_rt_i;
      end
      if (stall && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1))
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        valid_q[k]    <= 1'b0;
        dest_q[k]     <= '0;
        regwrite_q[k] <= 1'b0;
        memread_q[k]  <= 1'b0;
      end
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_use_rs_q <= 1'b0;
      ex_use_rt_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        valid_q[k]    <= valid_d[k];
        dest_q[k]     <= dest_d[k];
        regwrite_q[k] <= regwrite_d[k];
        memread_q[k]  <= memread_d[k];
      end
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_use_rs_q <= ex_use_rs_d;
      ex_use_rt_q <= ex_use_rt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
